// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch sequencer.
// This package also holds the saturating counter helper used by the top module.
package pc_seq_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [15:0] CNT_MAX          = 16'hFFFF;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == CNT_MAX) ? CNT_MAX : val + 16'd1;
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Combinational PC + 4 incrementer.
// The sum wraps modulo 2^XLEN.
module pc_incr #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  output logic [XLEN-1:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + XLEN'(4);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: boot bubble, stall hold, predicted branches,
// and mispredict redirects with flush, misalign pulse and a saturating redirect count.
module pc_fetch_sequencer #(
  parameter int unsigned     XLEN     = pc_seq_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(pc_seq_pkg::RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            pred_taken_i,
  input  logic [XLEN-1:0] pred_target_i,
  input  logic            mispredict_i,
  input  logic [XLEN-1:0] correct_pc_i,
  input  logic            imem_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            imem_req_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [15:0]     redirect_count_o
);

  import pc_seq_pkg::*;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            misalign_q, misalign_d;
  logic            redirect_take;
  logic            accept;

  pc_incr #(.XLEN(XLEN)) u_pc_incr (
    .pc_i       (pc_q),
    .pc_plus4_o (pc_plus4_o)
  );

  assign redirect_take = mispredict_i && (state_q != BOOT);
  assign accept        = imem_req_o && imem_ready_i && !stall_i && !mispredict_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:        state_d = FETCH;
      FETCH, HOLD: begin
        if (redirect_take) begin
          state_d = REDIRECT;
        end else if (accept) begin
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      REDIRECT:    state_d = redirect_take ? REDIRECT : FETCH;
      default:     state_d = BOOT;
    endcase
  end

  // Outputs are also forced low while reset is held, so nothing leaks out during reset.
  always_comb begin
    imem_req_o = 1'b0;
    unique case (state_q)
      FETCH, HOLD: imem_req_o = rst_n;
      default:     imem_req_o = 1'b0;
    endcase
    flush_o = rst_n && redirect_take;
  end

  // Next PC: mispredict beats any fetch advance; a blocked fetch keeps pc_q.
  always_comb begin
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    if (redirect_take) begin
      pc_d       = {correct_pc_i[XLEN-1:2], 2'b00};
      misalign_d = |correct_pc_i[1:0];
      cnt_d      = sat_inc16(cnt_q);
    end else if (accept) begin
      if (pred_taken_i) begin
        pc_d       = {pred_target_i[XLEN-1:2], 2'b00};
        misalign_d = |pred_target_i[1:0];
      end else begin
        pc_d = pc_plus4_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      cnt_q      <= 16'd0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o             = pc_q;
  assign misalign_o       = misalign_q;
  assign redirect_count_o = cnt_q;

endmodule
